// File: rtl/picomips_param_if.sv
// Program-load bus: the host side writes instruction words {opcode, arg} into the core's program RAM.
interface picomips_param_if #(
  parameter int unsigned PMEM_DEPTH = 64,
  parameter int unsigned ARG_W      = 7
);
  logic                          Prog_we;
  logic [$clog2(PMEM_DEPTH)-1:0] Prog_addr;
  logic [ARG_W+3:0]              Prog_data;

  modport master (output Prog_we, Prog_addr, Prog_data);
  modport slave  (input  Prog_we, Prog_addr, Prog_data);
endinterface

// File: rtl/picomips_param.sv
// Parametrised picoMIPS accumulator core: loadable program RAM, branches, WAIT on a synchronised Go,
// HALT, LED output register and optional saturating arithmetic. Two cycles per instruction.
module picomips_param #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned NREGS      = 4,
  parameter int unsigned PMEM_DEPTH = 64,
  parameter int unsigned ARG_W      = 7,
  parameter int unsigned FRAC       = 4,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                          Clock,
  input  logic                          Reset,
  input  logic                          Run,
  picomips_param_if.slave               prog,
  input  logic [DATA_W-1:0]             SW,
  input  logic                          Go,
  output logic [DATA_W-1:0]             LED,
  output logic [$clog2(PMEM_DEPTH)-1:0] PC,
  output logic                          Waiting,
  output logic                          Halted
);
  localparam int unsigned AW = $clog2(PMEM_DEPTH);
  localparam int unsigned RW = $clog2(NREGS);
  localparam int unsigned IW = 4 + ARG_W;
  localparam int unsigned WW = 2 * DATA_W + ARG_W;
  localparam logic signed [WW-1:0] SMAX = signed'((WW'(1) << (DATA_W - 1)) - WW'(1));
  localparam logic signed [WW-1:0] SMIN = ~SMAX;

  typedef enum logic [3:0] {
    OP_NOP, OP_LSW, OP_LDI, OP_ADDI, OP_ADD, OP_SUB, OP_MULI, OP_ATR,
    OP_RTA, OP_WSW, OP_BZ,  OP_BN,   OP_JMP, OP_OUT, OP_HLT, OP_RSV
  } opcode_e;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT, S_HALT} state_e;

  state_e                   state_q;
  logic [IW-1:0]            mem [PMEM_DEPTH];
  logic [IW-1:0]            ir_q;
  logic [AW-1:0]            pc_q, pc_inc;
  logic signed [DATA_W-1:0] acc_q, acc_d, led_q;
  logic signed [DATA_W-1:0] regs_q [NREGS];
  logic                     go_s1_q, gs_q, waiting_q, halted_q;

  opcode_e                  op;
  logic [ARG_W-1:0]         arg;
  logic [RW-1:0]            ridx;
  logic [AW-1:0]            target;
  logic signed [WW-1:0]     imm_w, acc_w, reg_w, sw_w, wide;
  logic                     acc_we;

  assign op     = opcode_e'(ir_q[IW-1 -: 4]);
  assign arg    = ir_q[ARG_W-1:0];
  assign ridx   = arg[RW-1:0];
  assign target = arg[AW-1:0];
  assign pc_inc = pc_q + AW'(1);

  assign imm_w = {{(WW-ARG_W){arg[ARG_W-1]}}, arg};
  assign acc_w = {{(WW-DATA_W){acc_q[DATA_W-1]}}, acc_q};
  assign reg_w = {{(WW-DATA_W){regs_q[ridx][DATA_W-1]}}, regs_q[ridx]};
  assign sw_w  = {{(WW-DATA_W){SW[DATA_W-1]}}, SW};

  // Results are formed at full width, then clamped or truncated to DATA_W.
  always_comb begin
    wide   = '0;
    acc_we = 1'b1;
    case (op)
      OP_LSW:  wide = sw_w;
      OP_LDI:  wide = imm_w;
      OP_ADDI: wide = acc_w + imm_w;
      OP_ADD:  wide = acc_w + reg_w;
      OP_SUB:  wide = acc_w - reg_w;
      OP_MULI: wide = (acc_w * imm_w) >>> FRAC;
      OP_RTA:  wide = reg_w;
      default: acc_we = 1'b0;
    endcase
    if (SATURATE && wide > SMAX)      acc_d = SMAX[DATA_W-1:0];
    else if (SATURATE && wide < SMIN) acc_d = SMIN[DATA_W-1:0];
    else                              acc_d = wide[DATA_W-1:0];
  end

  // Writes are accepted in IDLE even on the cycle Run rises, so a load can overlap the start.
  always_ff @(posedge Clock) begin
    if (prog.Prog_we && (!Run || state_q == S_IDLE))
      mem[prog.Prog_addr] <= prog.Prog_data;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      acc_q     <= '0;
      led_q     <= '0;
      regs_q    <= '{default: '0};
      go_s1_q   <= 1'b0;
      gs_q      <= 1'b0;
      waiting_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      go_s1_q   <= Go;
      gs_q      <= go_s1_q;
      waiting_q <= 1'b0;
      halted_q  <= 1'b0;
      if (!Run) begin
        state_q <= S_IDLE;
        pc_q    <= '0;
      end else begin
        case (state_q)
          S_IDLE:  state_q <= S_FETCH;
          S_FETCH: begin
            ir_q    <= mem[pc_q];
            state_q <= S_EXEC;
          end
          S_EXEC: begin
            state_q <= S_FETCH;
            pc_q    <= pc_inc;
            if (acc_we) acc_q <= acc_d;
            case (op)
              OP_ATR: regs_q[ridx] <= acc_q;
              OP_WSW: if (gs_q != arg[0]) begin
                state_q   <= S_WAIT;
                pc_q      <= pc_q;
                waiting_q <= 1'b1;
              end
              OP_BZ:  if (acc_q == '0) pc_q <= target;
              OP_BN:  if (acc_q[DATA_W-1]) pc_q <= target;
              OP_JMP: pc_q <= target;
              OP_OUT: led_q <= acc_q;
              OP_HLT: begin
                state_q  <= S_HALT;
                pc_q     <= pc_q;
                halted_q <= 1'b1;
              end
              default: ;
            endcase
          end
          S_WAIT: begin
            if (gs_q == arg[0]) begin
              pc_q    <= pc_inc;
              state_q <= S_FETCH;
            end else begin
              waiting_q <= 1'b1;
            end
          end
          S_HALT:  halted_q <= 1'b1;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign LED     = led_q;
  assign PC      = pc_q;
  assign Waiting = waiting_q;
  assign Halted  = halted_q;
endmodule
